// File: rtl/pulse_player.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pulse_player
//
// Drain-side sequencer that sits directly behind the sample FIFO. It pops
// command words {last, hold_cnt, level} and drives level_out for hold_cnt+1
// cycles per word. Words are chained without a gap, so the waveform sent to
// the DAC/trigger path is cycle-exact.
//
// Optional build macro: PULSE_PLAYER_STATS_EN
//   When defined, adds the words_played and stall_cycles counter outputs.
//   When undefined, neither port nor any counter logic exists.
//
// Ports:
//   clk          in   rising-edge clock for all logic
//   reset        in   synchronous, active-high reset
//   start        in   one-cycle pulse, begins playback from IDLE
//   stop         in   one-cycle pulse, aborts playback (wins over start/load)
//   idle_level   in   level driven while not playing
//   fifo_dout    in   FIFO head word {last, hold_cnt, level}
//   fifo_empty   in   FIFO empty flag
//   fifo_rd      out  pop request, one cycle per consumed word (combinational)
//   level_out    out  registered output level
//   level_valid  out  high while level_out comes from a played word
//   busy         out  high in any state other than IDLE
//   done         out  one-cycle pulse after the final cycle of a last=1 word
//   underrun     out  sticky underrun flag, cleared by reset or accepted start
//   words_played out  (stats build) saturating count of fifo_rd pulses
//   stall_cycles out  (stats build) saturating count of cycles in STALL
// ---------------------------------------------------------------------------
module pulse_player #(
    parameter int LEVEL_W = 16,
    parameter int CNT_W   = 16,
    localparam int WORD_W = 1 + CNT_W + LEVEL_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [LEVEL_W-1:0] idle_level,
    input  logic [WORD_W-1:0]  fifo_dout,
    input  logic               fifo_empty,
    output logic               fifo_rd,
    output logic [LEVEL_W-1:0] level_out,
    output logic               level_valid,
    output logic               busy,
    output logic               done,
`ifdef PULSE_PLAYER_STATS_EN
    output logic [31:0]        words_played,
    output logic [31:0]        stall_cycles,
`endif
    output logic               underrun
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRIME = 2'd1;
    localparam logic [1:0] S_PLAY  = 2'd2;
    localparam logic [1:0] S_STALL = 2'd3;

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_remaining;
    logic               r_last_q;
    logic               r_empty_q;
    logic [LEVEL_W-1:0] r_level_out;
    logic               r_level_valid;
    logic               r_done;
    logic               r_underrun;

    logic               w_avail;
    logic               w_load;
    logic               w_final;
    logic               w_start_acc;
    logic               w_word_last;
    logic [CNT_W-1:0]   w_word_hold;
    logic [LEVEL_W-1:0] w_word_level;

    assign w_word_last  = fifo_dout[WORD_W-1];
    assign w_word_hold  = fifo_dout[CNT_W+LEVEL_W-1:LEVEL_W];
    assign w_word_level = fifo_dout[LEVEL_W-1:0];

    // The FIFO's registered dout needs one cycle after it turns non-empty
    // before the head word can be trusted, hence the delayed empty flag.
    assign w_avail     = !fifo_empty && !r_empty_q;
    assign w_final     = (r_remaining == '0);
    assign w_start_acc = (r_state == S_IDLE) && start && !stop;

    // Pop decision. Reset and stop both suppress the pop in their own cycle,
    // so no word is lost to a cycle that is being discarded.
    always_comb begin
        w_load = 1'b0;
        if (!reset && !stop) begin
            case (r_state)
                S_PRIME: w_load = w_avail;
                S_PLAY:  w_load = w_final && !r_last_q && w_avail;
                S_STALL: w_load = w_avail;
                default: w_load = 1'b0;
            endcase
        end
    end

    assign fifo_rd     = w_load;
    assign level_out   = r_level_out;
    assign level_valid = r_level_valid;
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign underrun    = r_underrun;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_remaining   <= '0;
            r_last_q      <= 1'b0;
            r_empty_q     <= 1'b1;
            r_level_out   <= '0;
            r_level_valid <= 1'b0;
            r_done        <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_empty_q <= fifo_empty;
            r_done    <= 1'b0;
            if (stop) begin
                // Abort: underrun is left untouched, no done pulse.
                r_state       <= S_IDLE;
                r_level_out   <= idle_level;
                r_level_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_level_out   <= idle_level;
                        r_level_valid <= 1'b0;
                        if (start) begin
                            r_underrun <= 1'b0;
                            r_state    <= S_PRIME;
                        end
                    end
                    S_PRIME: begin
                        // Waiting for the first word is not an underrun.
                        if (w_load) begin
                            r_level_out   <= w_word_level;
                            r_level_valid <= 1'b1;
                            r_remaining   <= w_word_hold;
                            r_last_q      <= w_word_last;
                            r_state       <= S_PLAY;
                        end
                    end
                    S_PLAY: begin
                        if (!w_final) begin
                            r_remaining <= r_remaining - CNT_W'(1);
                        end else if (r_last_q) begin
                            r_done        <= 1'b1;
                            r_level_out   <= idle_level;
                            r_level_valid <= 1'b0;
                            r_state       <= S_IDLE;
                        end else if (w_load) begin
                            // Next word chained in with no gap.
                            r_level_out   <= w_word_level;
                            r_level_valid <= 1'b1;
                            r_remaining   <= w_word_hold;
                            r_last_q      <= w_word_last;
                        end else begin
                            // Level is held, only the valid flag drops.
                            r_underrun    <= 1'b1;
                            r_level_valid <= 1'b0;
                            r_state       <= S_STALL;
                        end
                    end
                    S_STALL: begin
                        if (w_load) begin
                            r_level_out   <= w_word_level;
                            r_level_valid <= 1'b1;
                            r_remaining   <= w_word_hold;
                            r_last_q      <= w_word_last;
                            r_state       <= S_PLAY;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef PULSE_PLAYER_STATS_EN
    logic [31:0] r_words_played;
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (reset || w_start_acc) begin
            r_words_played <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_load && (r_words_played != 32'hFFFF_FFFF)) begin
                r_words_played <= r_words_played + 32'd1;
            end
            if ((r_state == S_STALL) && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign words_played = r_words_played;
    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_pulse_player.sv
`timescale 1ns/1ps
// Testbench for pulse_player: directed scenarios, FIFO model held in a queue,
// expected output levels queued as words are pushed and consumed whenever
// level_valid is observed.
module tb_pulse_player;

    localparam int LEVEL_W = 16;
    localparam int CNT_W   = 16;
    localparam int WORD_W  = 1 + CNT_W + LEVEL_W;
    localparam logic [LEVEL_W-1:0] IDLE_LVL = 16'h1234;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               stop;
    logic [LEVEL_W-1:0] idle_level;
    logic [WORD_W-1:0]  fifo_dout;
    logic               fifo_empty;
    logic               fifo_rd;
    logic [LEVEL_W-1:0] level_out;
    logic               level_valid;
    logic               busy;
    logic               done;
    logic               underrun;
`ifdef PULSE_PLAYER_STATS_EN
    logic [31:0]        words_played;
    logic [31:0]        stall_cycles;
`endif

    pulse_player #(.LEVEL_W(LEVEL_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .idle_level  (idle_level),
        .fifo_dout   (fifo_dout),
        .fifo_empty  (fifo_empty),
        .fifo_rd     (fifo_rd),
        .level_out   (level_out),
        .level_valid (level_valid),
        .busy        (busy),
        .done        (done),
`ifdef PULSE_PLAYER_STATS_EN
        .words_played(words_played),
        .stall_cycles(stall_cycles),
`endif
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [WORD_W-1:0]  fifo_q[$];
    logic [LEVEL_W-1:0] exp_q[$];

    // Snapshot of DUT outputs taken mid-cycle (negedge).
    logic               s_rd, s_valid, s_busy, s_done, s_under, s_empty;
    logic [LEVEL_W-1:0] s_lvl;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fifo_refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    task automatic push_word(input logic last, input logic [CNT_W-1:0] hold,
                             input logic [LEVEL_W-1:0] lvl);
        fifo_q.push_back({last, hold, lvl});
        for (int i = 0; i <= int'(hold); i++) exp_q.push_back(lvl);
        fifo_refresh();
    endtask

    // One clock cycle: sample at negedge, check scoreboard and the no-pop-
    // while-empty rule, then pop the FIFO model after the edge if requested.
    task automatic cyc();
        logic [LEVEL_W-1:0] e;
        @(negedge clk);
        s_rd = fifo_rd; s_valid = level_valid; s_busy = busy; s_done = done;
        s_under = underrun; s_empty = fifo_empty; s_lvl = level_out;
        chk("rd_while_empty", {63'd0, s_rd & s_empty}, 64'd0);
        if (s_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid_level", {48'd0, s_lvl}, 64'hDEAD_0000);
            end else begin
                e = exp_q.pop_front();
                chk("level", {48'd0, s_lvl}, {48'd0, e});
            end
        end
        @(posedge clk);
        #1;
        if (s_rd && fifo_q.size() != 0) void'(fifo_q.pop_front());
        fifo_refresh();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; idle_level = IDLE_LVL;
        fifo_refresh();

        // Reset state
        cyc();
        cyc();
        chk("rst_rd", s_rd, 0);       chk("rst_level", s_lvl, 0);
        chk("rst_valid", s_valid, 0); chk("rst_busy", s_busy, 0);
        chk("rst_done", s_done, 0);   chk("rst_underrun", s_under, 0);
        reset = 1'b0;

        // Scenario 1: two preloaded words, hold 2 then last hold 0
        push_word(1'b0, 16'd2, 16'h00AA);
        push_word(1'b1, 16'd0, 16'h0055);
        cyc();
        cyc();
        chk("s1_idle_level", s_lvl, IDLE_LVL);
        for (int c = 0; c <= 7; c++) begin
            start = (c == 0);
            cyc();
            chk($sformatf("s1_rd c%0d", c), s_rd, (c == 1 || c == 4));
            chk($sformatf("s1_valid c%0d", c), s_valid, (c >= 2 && c <= 5));
            chk($sformatf("s1_done c%0d", c), s_done, (c == 6));
            chk($sformatf("s1_busy c%0d", c), s_busy, (c >= 1 && c <= 5));
            if (c >= 6) chk($sformatf("s1_idle c%0d", c), s_lvl, IDLE_LVL);
        end
        chk("s1_sb_drained", exp_q.size(), 0);

        // Scenario 2: four hold-0 words back to back
        for (int i = 1; i <= 4; i++) push_word(i == 4, 16'd0, LEVEL_W'(i));
        cyc();
        cyc();
        for (int c = 0; c <= 7; c++) begin
            start = (c == 0);
            cyc();
            chk($sformatf("s2_rd c%0d", c), s_rd, (c >= 1 && c <= 4));
            chk($sformatf("s2_valid c%0d", c), s_valid, (c >= 2 && c <= 5));
            chk($sformatf("s2_done c%0d", c), s_done, (c == 6));
        end
        chk("s2_sb_drained", exp_q.size(), 0);

        // Scenario 3: underrun between two words
        push_word(1'b0, 16'd1, 16'h0111);
        cyc();
        cyc();
        for (int c = 0; c <= 14; c++) begin
            start = (c == 0);
            cyc();
            if (c == 8) push_word(1'b1, 16'd0, 16'h0222);
            chk($sformatf("s3_rd c%0d", c), s_rd, (c == 1 || c == 10));
            chk($sformatf("s3_valid c%0d", c), s_valid, (c == 2 || c == 3 || c == 11));
            chk($sformatf("s3_done c%0d", c), s_done, (c == 12));
            chk($sformatf("s3_underrun c%0d", c), s_under, (c >= 4));
            chk($sformatf("s3_busy c%0d", c), s_busy, (c >= 1 && c <= 11));
            if (c >= 4 && c <= 10) chk($sformatf("s3_hold c%0d", c), s_lvl, 16'h0111);
        end
        chk("s3_sb_drained", exp_q.size(), 0);
`ifdef PULSE_PLAYER_STATS_EN
        chk("s3_words_played", words_played, 2);
        chk("s3_stall_cycles", stall_cycles, 7);
`endif

        // Scenario 4: stop in the second cycle of a hold-10 word
        push_word(1'b0, 16'd10, 16'h0333);
        push_word(1'b1, 16'd0, 16'h0444);
        cyc();
        cyc();
        for (int c = 0; c <= 8; c++) begin
            start = (c == 0);
            stop  = (c == 3);
            cyc();
            chk($sformatf("s4_rd c%0d", c), s_rd, (c == 1));
            chk($sformatf("s4_valid c%0d", c), s_valid, (c == 2 || c == 3));
            chk($sformatf("s4_busy c%0d", c), s_busy, (c >= 1 && c <= 3));
            chk($sformatf("s4_done c%0d", c), s_done, 0);
            chk($sformatf("s4_underrun c%0d", c), s_under, (c == 0));
            if (c >= 4) chk($sformatf("s4_idle c%0d", c), s_lvl, IDLE_LVL);
`ifdef PULSE_PLAYER_STATS_EN
            if (c == 1) begin
                chk("s4_words_cleared", words_played, 0);
                chk("s4_stall_cleared", stall_cycles, 0);
            end
`endif
        end
        stop = 1'b0;
        chk("s4_sb_left", exp_q.size(), 10);
        repeat (9) void'(exp_q.pop_front());
        chk("s4_fifo_left", fifo_q.size(), 1);
        chk("s4_fifo_head", fifo_dout, {1'b1, 16'd0, 16'h0444});

        // stop wins over start in IDLE, and over a load in PRIME
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        cyc();
        chk("stop_vs_start_busy", s_busy, 0);
        start = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b1;
        cyc();
        chk("stop_vs_load_rd", s_rd, 0);
        stop = 1'b0;
        cyc();
        chk("stop_vs_load_busy", s_busy, 0);
        chk("stop_vs_load_fifo", fifo_q.size(), 1);

        // Scenario 5: reset during PLAY with underrun set
        fifo_q.delete();
        exp_q.delete();
        fifo_refresh();
        push_word(1'b0, 16'd0, 16'h0666);
        cyc();
        cyc();
        for (int c = 0; c <= 8; c++) begin
            start = (c == 0);
            reset = (c == 7);
            cyc();
            if (c == 3) begin
                push_word(1'b0, 16'd1, 16'h0777);
                push_word(1'b1, 16'd0, 16'h0888);
            end
            chk($sformatf("s5_rd c%0d", c), s_rd, (c == 1 || c == 5));
            chk($sformatf("s5_underrun c%0d", c), s_under, (c >= 3 && c <= 7));
        end
        reset = 1'b0;
        chk("s5_rst_level", s_lvl, 0);  chk("s5_rst_valid", s_valid, 0);
        chk("s5_rst_busy", s_busy, 0);  chk("s5_rst_done", s_done, 0);
        chk("s5_sb_left", exp_q.size(), 1);
        chk("s5_fifo_left", fifo_q.size(), 1);
`ifdef PULSE_PLAYER_STATS_EN
        chk("s5_rst_words", words_played, 0);
        chk("s5_rst_stall", stall_cycles, 0);
`endif
        exp_q.delete();

        // Start with an empty FIFO waits in PRIME
        fifo_q.delete();
        fifo_refresh();
        for (int c = 0; c <= 5; c++) begin
            start = (c == 0);
            cyc();
            chk($sformatf("prime_rd c%0d", c), s_rd, 0);
            chk($sformatf("prime_busy c%0d", c), s_busy, (c >= 1));
            chk($sformatf("prime_underrun c%0d", c), s_under, 0);
        end
        start = 1'b0; stop = 1'b1;
        cyc();
        stop = 1'b0;
        cyc();
        chk("prime_stop_busy", s_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_player.md
Name: pulse_player

Overview:
- Drain-side sequencer that sits directly downstream of the sample FIFO.
- Pops command words {last, hold_cnt, level} from the FIFO and drives level_out for hold_cnt+1 cycles per word.
- Chains words with no gap between them, which produces a cycle-exact waveform toward the DAC/trigger path.
- Handles start, abort, end-of-sequence, and FIFO underrun.

Parameters:
- LEVEL_W, 16, width of the output level field.
- CNT_W, 16, width of the hold-count field.
- WORD_W, 1+CNT_W+LEVEL_W (derived, not overridable), FIFO word width. Bit WORD_W-1 = last; [CNT_W+LEVEL_W-1:LEVEL_W] = hold_cnt; [LEVEL_W-1:0] = level.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins playback from IDLE.
- stop  in  1  one-cycle pulse; aborts playback.
- idle_level  in  LEVEL_W  value driven while not playing.
- fifo_dout  in  WORD_W  FIFO head word.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd  out  1  pop request; asserted for one cycle per consumed word.
- level_out  out  LEVEL_W  registered output level.
- level_valid  out  1  high while level_out comes from a played word.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the final cycle of a last=1 word completes.
- underrun  out  1  sticky underrun flag.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, fifo_rd=0, level_out=0, level_valid=0, busy=0, done=0, underrun=0, remaining=0, empty_q=1.
- empty_q is fifo_empty registered by one cycle.
- Word available (avail) = !fifo_empty && !empty_q. This gives the FIFO's registered dout one cycle to settle after it becomes non-empty.
- fifo_rd is combinational: fifo_rd = load, where load is defined per state below.
- When a word loads:
  - fifo_dout is sampled in the same cycle fifo_rd is high.
  - level_out/level_valid update on the next edge.
  - remaining <= hold_cnt; last_q <= last.
- States:
  - IDLE:
    - level_out <= idle_level every cycle; level_valid=0.
    - start && !stop clears underrun and moves to PRIME.
  - PRIME:
    - load = avail.
    - On load, go to PLAY.
    - Otherwise wait indefinitely; no underrun is flagged here.
  - PLAY:
    - level_valid=1.
    - If remaining != 0, decrement remaining.
    - If remaining == 0 (final cycle of the word):
      - last_q=1: done pulses next cycle; go to IDLE.
      - Else if avail: load=1; stay in PLAY with no gap.
      - Else: set underrun; go to STALL.
  - STALL:
    - level_out holds the last played level; level_valid=0.
    - load = avail; on load, go to PLAY.
- Latency:
  - start at cycle 0 with the FIFO non-empty for at least 2 cycles: fifo_rd in cycle 1; level_out valid in cycles 2 .. 2+hold_cnt.
  - hold_cnt=0 gives exactly one cycle per word.
  - Back-to-back hold_cnt=0 words pop on consecutive cycles.
- Width rules:
  - hold_cnt is unsigned; the maximum 2^CNT_W-1 gives 2^CNT_W cycles.
  - remaining has no wrap: it only decrements from a non-zero value.
- stop:
  - Accepted in any state. Next state is IDLE; fifo_rd is forced 0 in the stop cycle.
  - No done pulse; underrun is unchanged.
  - stop wins over start and over load in the same cycle.
  - stop in IDLE has no effect.
- start outside IDLE is ignored.
- Reset mid-operation returns every output to its reset value on the next edge. No pop is issued in the reset cycle.
- The block never asserts fifo_rd while fifo_empty=1.

Optional Feature:
- PULSE_PLAYER_STATS_EN defined:
  - Adds output words_played [31:0]: count of fifo_rd pulses.
  - Saturates at 0xFFFFFFFF.
  - Cleared by reset and by an accepted start.
  - Adds output stall_cycles [31:0]: cycles spent in STALL, with the same clear and saturation rules.
- Not defined: neither port exists and no counter logic is built.

Test Plan:
- FIFO preloaded {0,2,0x00AA},{1,0,0x0055}; start at cycle 0 -> fifo_rd at cycles 1 and 4; level_out 0x00AA in cycles 2-4, 0x0055 in cycle 5; done at cycle 6; level_out=idle_level from cycle 6.
- Four words, hold_cnt=0, levels 1,2,3,4, last on word 4 -> level_out 1,2,3,4 on consecutive cycles; level_valid continuous; exactly four fifo_rd pulses.
- Two words; second word pushed 5 cycles after the first word finishes -> underrun=1; level_valid=0 for the stall; level held; playback resumes; done pulses; underrun stays 1 until the next start.
- stop in the second cycle of a hold_cnt=10 word -> IDLE next edge; no fifo_rd in the stop cycle; no done; FIFO content beyond the popped word untouched.
- reset asserted during PLAY with underrun=1 -> all outputs return to reset values (level_out=0, underrun=0); start with an empty FIFO -> waits in PRIME with busy=1 and no fifo_rd.
- With PULSE_PLAYER_STATS_EN: run the underrun scenario -> words_played=2, stall_cycles=5 or more (bench checks the exact value); next start clears both counters to 0.
